// File: rtl/sl_reciever.sv
// sl_reciever: two-wire serial word receiver (sl0 low = 0, sl1 low = 1, both low = stop).
// Ports: clk, reset (async, active high), enable, sl0/sl1 (idle-high raw lines),
//   bitCount (expected data bits - 1) -> dataOut (MSB-aligned word), wordInProces,
//   wordReady, parityValid (odd parity), bitCountValid.
// Option: define SL_RECIEVER_GLITCH_FILTER_EN to require 2 equal samples per line level.
module sl_reciever (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sl0,
  input  logic        sl1,
  input  logic [4:0]  bitCount,
  output logic [31:0] dataOut,
  output logic        wordInProces,
  output logic        wordReady,
  output logic        parityValid,
  output logic        bitCountValid
);
  logic [1:0] s0, s1;
  logic l0, l1, low, done, stop;
  logic in_low, seen0, seen1, pend, pbit, dpar;
  logic [31:0] sr;
  logic [5:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s0 <= 2'b11;
      s1 <= 2'b11;
    end else begin
      s0 <= {s0[0], sl0};
      s1 <= {s1[0], sl1};
    end
`ifdef SL_RECIEVER_GLITCH_FILTER_EN
  logic p0, p1, f0, f1;
  // level passes through only once the current and previous samples agree
  assign l0 = (s0[1] == p0) ? p0 : f0;
  assign l1 = (s1[1] == p1) ? p1 : f1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p0 <= 1'b1;
      p1 <= 1'b1;
      f0 <= 1'b1;
      f1 <= 1'b1;
    end else begin
      p0 <= s0[1];
      p1 <= s1[1];
      f0 <= l0;
      f1 <= l1;
    end
`else
  assign l0 = s0[1];
  assign l1 = s1[1];
`endif
  assign low  = ~l0 | ~l1;
  assign done = in_low & ~low;
  assign stop = seen0 & seen1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dataOut       <= '0;
      wordInProces  <= 1'b0;
      wordReady     <= 1'b0;
      parityValid   <= 1'b0;
      bitCountValid <= 1'b0;
      in_low        <= 1'b0;
      seen0         <= 1'b0;
      seen1         <= 1'b0;
      pend          <= 1'b0;
      pbit          <= 1'b0;
      dpar          <= 1'b0;
      sr            <= '0;
      cnt           <= '0;
    end else if (!enable) begin
      in_low       <= 1'b0;
      seen0        <= 1'b0;
      seen1        <= 1'b0;
      wordInProces <= 1'b0;
      pend         <= 1'b0;
      dpar         <= 1'b0;
      sr           <= '0;
      cnt          <= '0;
    end else begin
      in_low <= low;
      seen0  <= low & (seen0 | ~l0);
      seen1  <= low & (seen1 | ~l1);
      if (done) begin
        if (stop) begin
          // a stop only matters inside a word; the pending bit is the parity bit
          if (wordInProces) begin
            dataOut       <= sr;
            parityValid   <= pend & (dpar ^ pbit);
            bitCountValid <= cnt == {1'b0, bitCount} + 6'd1;
            wordReady     <= 1'b1;
            wordInProces  <= 1'b0;
          end
        end else if (!wordInProces) begin
          wordInProces <= 1'b1;
          wordReady    <= 1'b0;
          sr           <= '0;
          cnt          <= '0;
          dpar         <= 1'b0;
          pend         <= 1'b1;
          pbit         <= seen1;
        end else begin
          // the previous pending bit is now known to be data; dpar keeps parity
          // exact even when more than 32 bits have been shifted through
          if (pend) begin
            sr   <= {pbit, sr[31:1]};
            cnt  <= (cnt == 6'd33) ? cnt : cnt + 6'd1;
            dpar <= dpar ^ pbit;
          end
          pend <= 1'b1;
          pbit <= seen1;
        end
      end
    end
endmodule

// File: tb/tb_sl_reciever.sv
// tb_sl_reciever: scoreboard bench for sl_reciever with directed words.
module tb_sl_reciever;
  localparam int PH = 6;
  typedef struct {logic [31:0] d; logic pv; logic bv;} exp_t;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, sl0 = 1'b1, sl1 = 1'b1;
  logic [4:0] bitCount = 5'd7;
  logic [31:0] dataOut;
  logic wordInProces, wordReady, parityValid, bitCountValid;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic wr_q = 1'b0;
  sl_reciever dut (
    .clk(clk), .reset(reset), .enable(enable), .sl0(sl0), .sl1(sl1),
    .bitCount(bitCount), .dataOut(dataOut), .wordInProces(wordInProces),
    .wordReady(wordReady), .parityValid(parityValid), .bitCountValid(bitCountValid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (wordReady && !wr_q) begin
      if (q.size() == 0) chk("unexpected_wordReady", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dataOut", dataOut, e.d);
        chk("parityValid", {31'd0, parityValid}, {31'd0, e.pv});
        chk("bitCountValid", {31'd0, bitCountValid}, {31'd0, e.bv});
      end
    end
    wr_q = wordReady;
  end
  task automatic sym(input int k);
    @(negedge clk);
    sl0 = (k == 1);
    sl1 = (k == 0);
    repeat (PH) @(negedge clk);
    sl0 = 1'b1;
    sl1 = 1'b1;
    repeat (PH) @(negedge clk);
  endtask
  task automatic send_word(input logic [31:0] d, input int n, input logic p,
                           input logic [31:0] ed, input logic epv, input logic ebv);
    int lat;
    q.push_back('{ed, epv, ebv});
    for (int i = 0; i < n; i++) sym(int'(d[i % 32]));
    sym(int'(p));
    @(negedge clk);
    sl0 = 1'b0;
    sl1 = 1'b0;
    repeat (PH) @(negedge clk);
    sl0 = 1'b1;
    sl1 = 1'b1;
    lat = 0;
    while (!wordReady && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("stop_latency_le4", (lat <= 4) ? 32'd1 : 32'd0, 32'd1);
    repeat (PH) @(negedge clk);
  endtask
  initial begin
    #1;
    chk("reset_dataOut", dataOut, 32'd0);
    chk("reset_wordReady", {31'd0, wordReady}, 32'd0);
    chk("reset_wordInProces", {31'd0, wordInProces}, 32'd0);
    chk("reset_parityValid", {31'd0, parityValid}, 32'd0);
    chk("reset_bitCountValid", {31'd0, bitCountValid}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sym(2);
    chk("idle_stop_wip", {31'd0, wordInProces}, 32'd0);
    chk("idle_stop_wr", {31'd0, wordReady}, 32'd0);
    bitCount = 5'd7;
    send_word(32'hA5, 8, 1'b1, 32'hA500_0000, 1'b1, 1'b1);
    send_word(32'hA5, 8, 1'b0, 32'hA500_0000, 1'b0, 1'b1);
    bitCount = 5'd14;
    send_word(32'h1234, 16, 1'b0, 32'h1234_0000, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("hold_dataOut", dataOut, 32'h1234_0000);
    chk("hold_wordReady", {31'd0, wordReady}, 32'd1);
    bitCount = 5'd7;
    for (int i = 0; i < 5; i++) sym(i % 2);
    chk("midword_wip", {31'd0, wordInProces}, 32'd1);
    chk("midword_wr", {31'd0, wordReady}, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    chk("abort_wip", {31'd0, wordInProces}, 32'd0);
    chk("abort_dataOut", dataOut, 32'h1234_0000);
    send_word(32'h3C, 8, 1'b1, 32'h3C00_0000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) sym(1);
    chk("prereset_wip", {31'd0, wordInProces}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("areset_dataOut", dataOut, 32'd0);
    chk("areset_wip", {31'd0, wordInProces}, 32'd0);
    chk("areset_wr", {31'd0, wordReady}, 32'd0);
    chk("areset_flags", {30'd0, parityValid, bitCountValid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_word(32'h5A, 8, 1'b1, 32'h5A00_0000, 1'b1, 1'b1);
    bitCount = 5'd31;
    send_word(32'hDEAD_BEEF, 32, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    send_word(32'hFFFF_FFFF, 33, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef SL_RECIEVER_GLITCH_FILTER_EN
    @(negedge clk);
    sl1 = 1'b0;
    @(negedge clk);
    sl1 = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_wip", {31'd0, wordInProces}, 32'd0);
    chk("glitch_wr", {31'd0, wordReady}, 32'd1);
    chk("glitch_dataOut", dataOut, 32'hFFFF_FFFF);
`endif
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sl_reciever.md
SL_RECIEVER -- requirements
Module: sl_reciever

Interface
REQ-001 The module SHALL have these ports: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 enable  input  1  receiver enable; low aborts any word in progress and ignores the lines.
REQ-004 sl0  input  1  serial line 0, idle high, asynchronous to clk.
REQ-005 sl1  input  1  serial line 1, idle high, asynchronous to clk.
REQ-006 bitCount  input  5  expected data length minus one (7 means 8 data bits).
REQ-007 dataOut  output  32  last received word, MSB-aligned.
REQ-008 wordInProces  output  1  high while a word is being received.
REQ-009 wordReady  output  1  high when dataOut/flags hold a completed word.
REQ-010 parityValid  output  1  parity check result of last word.
REQ-011 bitCountValid  output  1  length check result of last word.

Function
REQ-012 sl0 and sl1 SHALL each pass through a 2-flop synchronizer before any use; clk is at least 4x faster than one line phase.
REQ-013 Low phase: any interval with at least one synchronized line low; it ends when both lines are high again.
REQ-014 Symbol decode at end of low phase: only sl0 was ever low -> bit 0; only sl1 -> bit 1; both low at the same time at any point -> stop.
REQ-015 The first low phase while idle and enabled SHALL set wordInProces, clear wordReady, and clear the internal shift register, bit counter and pending-bit flag.
REQ-016 Each decoded bit SHALL be held as pending; when a further bit arrives, the previous pending bit SHALL shift in at bit 31 of the 32-bit shift register (right shift) and the counter SHALL increment, saturating at 33.
REQ-017 On stop, the pending bit SHALL be the parity bit; no pending bit means parity invalid.
REQ-018 Odd parity: parityValid = 1 iff the data ones plus the parity bit total an odd count.
REQ-019 bitCountValid = 1 iff the data-bit count equals bitCount+1; the count excludes parity; more than 32 data bits is always invalid.
REQ-020 On stop: dataOut <= shift register; update both flags; set wordReady; clear wordInProces.
REQ-021 All four are updated on the same clock, at most 4 clk after both raw lines return high.
REQ-022 Unfilled low-order dataOut bits SHALL be 0; for 8 bits b0..b7 sent first-to-last, dataOut[31:24] = {b7..b0} and dataOut[23:0] = 0.
REQ-023 dataOut, wordReady and both flags SHALL hold until the next word starts or reset.
REQ-024 enable low SHALL clear wordInProces and discard the partial word, leaving dataOut, wordReady and the flags unchanged.
REQ-025 A stop received while idle SHALL be ignored.

Reset
REQ-026 reset high SHALL asynchronously clear dataOut, wordReady, wordInProces, parityValid, bitCountValid, the synchronizers (to 1 = idle), the shift register, the counter and the pending flag.
REQ-027 Reset mid-word SHALL abort the word with no wordReady.
REQ-028 After reset deassertion the receiver SHALL be idle and accept a new word.

Configuration
REQ-029 Macro SL_RECIEVER_GLITCH_FILTER_EN defined: a synchronized line counts as low only after 2 consecutive low samples and as high only after 2 consecutive high samples; this adds 1 clk latency.
REQ-030 SL_RECIEVER_GLITCH_FILTER_EN undefined: the synchronizer outputs are used directly.

Verification
REQ-031 bitCount=7, send 8 bits 0xA5 LSB-first, parity 1 (four ones), stop -> dataOut=0xA5000000, wordReady=1, parityValid=1, bitCountValid=1.
REQ-032 Same as REQ-031 with parity 0 -> parityValid=0, bitCountValid=1, dataOut=0xA5000000.
REQ-033 bitCount=14, send 16 bits 0x1234 with correct parity -> dataOut=0x12340000, bitCountValid=0, parityValid=1.
REQ-034 Mid-word after 5 bits: drop enable for 2 clk, re-enable, send a full 8-bit word 0x3C with correct parity -> dataOut=0x3C000000 and no wordReady between the abort and the new stop.
REQ-035 Pulse reset while wordInProces=1 -> all outputs 0 immediately; a following 8-bit word is received correctly.
REQ-036 With SL_RECIEVER_GLITCH_FILTER_EN defined, a 1-clk low glitch on sl1 while idle -> no wordInProces and no state change.
